// File: rtl/psum_collector_pkg.sv
// Shared constants and helpers for the systolic array south-edge drain.
// Also used by the MAC array and the west-side feeder for psum slicing.
package psum_collector_pkg;

  localparam int DEF_COL       = 8;
  localparam int DEF_PSUM_BW   = 16;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_AF_MARGIN = 16;

  // Number of bits needed to address 'value' entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // LSB position of column c inside a packed col-wide psum bus.
  function automatic int psum_lsb(input int c, input int bw);
    return c * bw;
  endfunction

endpackage

// File: rtl/psum_fifo_col.sv
// Single-column first-word-fall-through FIFO for the psum drain.
// A write to a full FIFO is accepted when a read happens in the same cycle;
// otherwise it is dropped and o_wr_drop is raised for that cycle.
module psum_fifo_col
  import psum_collector_pkg::*;
#(
  parameter  int psum_bw = DEF_PSUM_BW,
  parameter  int depth   = DEF_DEPTH,
  localparam int PW      = clog2(depth),
  localparam int CW      = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [psum_bw-1:0] i_wr_data,
  input  logic               i_rd_en,
  output logic [psum_bw-1:0] o_rd_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [CW-1:0]      o_count,
  output logic               o_wr_drop
);

  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [psum_bw-1:0] r_mem [depth];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_pop;
  logic               w_accept;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH_C);
  assign w_pop     = i_rd_en & ~o_empty;
  assign w_accept  = i_wr_en & (~o_full | w_pop);
  assign o_wr_drop = i_wr_en & ~w_accept;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally at depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_accept && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_accept && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/psum_collector.sv
// South-edge psum collector: one FIFO per array column absorbs the column
// skew, and a row is released only when every column holds an entry.
// Optional build macro PSUM_COLLECTOR_RELU_EN applies a signed ReLU to
// each output slice; stored data and all flags are unaffected by it.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter  int col       = DEF_COL,
  parameter  int psum_bw   = DEF_PSUM_BW,
  parameter  int depth     = DEF_DEPTH,
  parameter  int af_margin = DEF_AF_MARGIN,
  localparam int CW        = clog2(depth) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in_psum,
  input  logic [col-1:0]         in_valid,
  output logic [psum_bw*col-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   almost_full,
  output logic [col-1:0]         full,
  output logic                   overflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AF_C    = CW'(af_margin);

  logic [psum_bw*col-1:0] w_head;
  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_drop;
  logic [col-1:0]         w_af;
  logic [CW-1:0]          w_count [col];
  logic                   w_pop;
  logic                   r_overflow;

`ifdef PSUM_COLLECTOR_RELU_EN
  function automatic logic [psum_bw-1:0] relu(input logic signed [psum_bw-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction
`endif

  genvar g;
  generate
    for (g = 0; g < col; g++) begin : g_col
      psum_fifo_col #(
        .psum_bw (psum_bw),
        .depth   (depth)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (in_valid[g]),
        .i_wr_data (in_psum[psum_lsb(g, psum_bw) +: psum_bw]),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head[psum_lsb(g, psum_bw) +: psum_bw]),
        .o_empty   (w_empty[g]),
        .o_full    (full[g]),
        .o_count   (w_count[g]),
        .o_wr_drop (w_drop[g])
      );

      // Free entries at or below the margin warn the controller early.
      assign w_af[g] = ((DEPTH_C - w_count[g]) <= AF_C);
    end
  endgenerate

  // A row exists only once every column has something at its head; the
  // pop then goes to all columns together so they stay aligned.
  assign out_valid   = &(~w_empty);
  assign w_pop       = out_valid & out_ready;
  assign almost_full = |w_af;
  assign overflow    = r_overflow;

  // Head row to the output, zeroed when no complete row is available.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < col; c++) begin
`ifdef PSUM_COLLECTOR_RELU_EN
        out_data[psum_lsb(c, psum_bw) +: psum_bw] = relu(w_head[psum_lsb(c, psum_bw) +: psum_bw]);
`else
        out_data[psum_lsb(c, psum_bw) +: psum_bw] = w_head[psum_lsb(c, psum_bw) +: psum_bw];
`endif
      end
    end
  end

  // Sticky record of any dropped write; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_overflow <= 1'b0;
    else       r_overflow <= r_overflow | (|w_drop);
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- South-edge drain for the systolic MAC array.
- Captures the per-column partial-sum bus and per-column valid strobes. Columns arrive skewed by one cycle each, and each column is pushed into its own FIFO.
- Emits fully aligned col-wide psum vectors to downstream SRAM/post-processing over a valid/ready handshake.
- The array cannot stall, so the block raises almost_full early so the controller can stop issuing execute instructions.

Parameters:
- col, 8, number of array columns (one FIFO per column)
- psum_bw, 16, bits per partial sum
- depth, 64, entries per column FIFO; power of two, at least 4
- af_margin, 16, free-entry threshold for almost_full; must be less than depth

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_psum  input  psum_bw*col  array south outputs; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- in_valid  input  col  per-column write strobe from the array valid bus
- out_data  output  psum_bw*col  aligned row vector, same packing as in_psum
- out_valid  output  1  out_data holds one entry from every column
- out_ready  input  1  downstream accepts out_data
- almost_full  output  1  some column has at most af_margin free entries
- full  output  col  per-column FIFO full
- overflow  output  1  sticky: a write was dropped

Behaviour:
- Reset (async, highest priority, also mid-transfer):
  - all pointers and counts go to 0
  - full=0, almost_full=0, out_valid=0, overflow=0, out_data=0
  - FIFO contents need not be cleared
- Write, per column c, independent of the other columns:
  - A write is accepted when in_valid[c]=1 and either count_c<depth or a pop occurs in the same cycle.
  - On acceptance, the slice is stored at wr_ptr_c, wr_ptr_c increments modulo depth (natural wrap), and count_c increments unless a pop also occurs.
- Dropped write:
  - in_valid[c]=1 while count_c==depth with no pop: data discarded, count unchanged, overflow set on the next edge.
  - overflow stays set until reset.
- Read, first-word fall-through:
  - out_valid = AND over all columns of (count_c!=0), combinational from registered counts.
  - out_data = head entry of every column when out_valid=1, otherwise forced to 0.
  - Pop = out_valid & out_ready. A pop advances every rd_ptr_c by one and decrements every count_c, except where a write is accepted the same cycle.
  - Partial columns are never popped.
- Latency: an entry written at edge N can appear on out_data after edge N if every other column is already non-empty.
  - With standard array skew, vector k becomes valid one cycle after column col-1 writes its element k.
- Simultaneous write and pop on an empty column cannot occur, because out_valid requires non-empty.
- Simultaneous write and pop on a full column: the write is accepted and count stays at depth.
- full[c] = (count_c==depth), registered via count.
- almost_full = OR over columns of (depth-count_c <= af_margin).
- out_ready may toggle arbitrarily. out_data and out_valid must stay stable while out_valid=1 and out_ready=0, since no new head is exposed without a pop.
- Count width is clog2(depth)+1. Pointer width is clog2(depth).
- The datapath is pure storage; no arithmetic on psums unless the optional feature is enabled.

Optional Feature:
- Macro: PSUM_COLLECTOR_RELU_EN
- Defined:
  - each psum_bw slice of out_data passes through signed ReLU: negative values (MSB=1) output 0, others pass unchanged
  - applied combinationally after the head mux; stored data is unmodified
- Not defined: out_data is the raw stored psum.
- Handshake, counts and flags are identical in both builds.

Decomposition:
- Shared package/header holds:
  - default psum_bw, col and depth constants
  - a clog2 constant function
  - a psum slice-index helper, common with the MAC array and the west-side feeder
- One sub-module: psum_fifo_col.
  - Single-column FWFT FIFO: wr_en, wr_data, rd_en, rd_data, empty, full, count.
  - Write-when-full-with-read accepted.
  - Instantiated col times via generate.
- The top level holds out_valid AND, pop fan-out, almost_full OR-reduce, overflow sticky register, ReLU, and zero gating.

Test Plan:
- Reset: after reset deassert, all outputs are 0. Assert reset mid-stream holding 5 entries: out_valid drops to 0 asynchronously and counts return to 0.
- Skewed fill, col=8:
  - Stimulus: drive column c with value 16'h0100+c starting at cycle c, one entry each, out_ready=1.
  - Response: out_valid rises exactly one cycle after column 7 writes, and out_data={16'h0107,...,16'h0100} for one cycle.
- Backpressure:
  - Stimulus: out_ready=0, stream 10 aligned vectors.
  - Response: out_data holds vector 0 stable. With depth=64 and af_margin=16, almost_full stays low until count reaches 48. Releasing ready drains in order 0..9.
- Overflow:
  - Stimulus: fill column 3 to 64 with out_ready=0, then pulse in_valid[3].
  - Response: full[3]=1, overflow=1 from the next cycle, the dropped value never appears, and overflow persists after draining.
- Full with simultaneous pop: all columns full and out_ready=1 while writing every column. Counts stay 64, no overflow, and order is preserved across pointer wrap (more than 64 total entries).
- RELU build: column values 16'hFFF0 and 16'h0012 appear as 16'h0000 and 16'h0012. Without the macro, 16'hFFF0 appears unchanged.
